demux_sched_8ch: RTL

Sequencing controller for the 1-to-8 demultiplexer datapath. Accepts a word stream over a valid/ready handshake, chooses a destination channel and holds the word until that channel accepts it. Destination comes from the word itself (addressed mode) or from a rotating pointer over enabled channels (round-robin mode). Drives the demux select, supervises stalled channels with a timeout and counts discarded words.

---
 rtl/demux_sched_pkg.sv | 23 ++
 rtl/demux_sched_8ch_rr_pick.sv | 38 +++
 rtl/demux_sched_8ch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/demux_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : demux_sched_pkg                                           |
// | Purpose  : Shared constants and state type for the 8-channel demux   |
// |            sequencing controller.                                    |
// | Contents : MODE_ADDR / MODE_RR mode codes, NUM_CH, SEL_W, state_t    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package demux_sched_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/demux_sched_8ch_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_pick                                                   |
// | Purpose  : Combinational rotating-priority encoder. Returns the first |
// |            set bit of mask searching upward from base with wrap.     |
// | Ports    : mask  - candidate channels                                |
// |            base  - search start position                             |
// |            sel   - selected channel (base when nothing is found)     |
// |            found - at least one mask bit is set                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  base,
  output logic [SEL_W-1:0]  sel,
  output logic              found
);

  logic [SEL_W-1:0] w_idx;

  // Walk from the farthest offset back toward base so the closest hit wins.
  always_comb begin
    sel   = base;
    found = 1'b0;
    w_idx = base;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = base + SEL_W'(i);
      if (mask[w_idx]) begin
        sel   = w_idx;
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_sched_8ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : demux_sched_8ch                                           |
// | Purpose  : Sequencing controller for a 1-to-8 demux. Holds one word,  |
// |            routes it by address or round-robin, supervises stalls    |
// |            with a timeout and counts discarded words.                |
// | Ports    : clk, rst (async, active-high)                             |
// |            mode, chan_en, flush            - control                  |
// |            in_valid/in_ready/in_data/in_dest - upstream handshake    |
// |            out_data/out_sel/out_valid/out_ready - channel side       |
// |            drop_pulse, timeout_pulse, drop_cnt, busy - status        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module demux_sched_8ch
  import demux_sched_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [NUM_CH-1:0]   chan_en,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic [SEL_W-1:0]    in_dest,
  output logic [DW-1:0]       out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic                drop_pulse,
  output logic                timeout_pulse,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                busy
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             r_state;
  state_t             w_state_next;
  logic [DW-1:0]      r_data;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_drop_pulse;
  logic               r_timeout_pulse;

  logic [SEL_W-1:0]   w_rr_sel;
  logic               w_rr_found;
  logic [SEL_W-1:0]   w_dest;
  logic               w_deliver;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_load;
  logic               w_drop;
  logic               w_timeout;
  logic               w_flush_drop;
  logic               w_discard;

  rr_pick u_rr_pick (
    .mask  (chan_en),
    .base  (r_rr_ptr),
    .sel   (w_rr_sel),
    .found (w_rr_found)
  );

  assign w_deliver  = (r_state == ISSUE) && out_ready[r_sel];
  assign w_in_ready = !flush && ((r_state == EMPTY) || w_deliver) &&
                      !((mode == MODE_RR) && !w_rr_found);
  assign w_accept   = in_valid && w_in_ready;
  assign w_dest     = (mode == MODE_RR) ? w_rr_sel : in_dest;

  // Round-robin picks only enabled channels, so a drop is only possible
  // in addressed mode.
  assign w_load       = w_accept && chan_en[w_dest];
  assign w_drop       = w_accept && !chan_en[w_dest];
  // Flush takes precedence over a coincident timeout: one discard, no pulse.
  assign w_timeout    = (TIMEOUT > 0) && (r_state == ISSUE) && !w_deliver &&
                        !flush && (r_wait == c_wait_last);
  assign w_flush_drop = flush && (r_state == ISSUE) && !w_deliver;
  assign w_discard    = w_drop || w_timeout || w_flush_drop;

  always_comb begin
    w_state_next = r_state;
    if (w_load) begin
      w_state_next = ISSUE;
    end else if (w_deliver || w_timeout || w_flush_drop) begin
      w_state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= EMPTY;
      r_data          <= '0;
      r_sel           <= '0;
      r_rr_ptr        <= '0;
      r_wait          <= '0;
      r_drop_cnt      <= '0;
      r_drop_pulse    <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_drop_pulse    <= w_drop;
      r_timeout_pulse <= w_timeout;
      if (w_load) begin
        r_data <= in_data;
        r_sel  <= w_dest;
      end
      if (w_accept && (mode == MODE_RR)) begin
        r_rr_ptr <= w_rr_sel + 1'b1;
      end
      // Counts stall cycles of the word currently held; any change of
      // occupancy restarts it.
      if (w_load || w_deliver || (w_state_next == EMPTY)) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_discard && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    if (r_state == ISSUE) begin
      out_valid[r_sel] = 1'b1;
    end
  end

  assign in_ready      = w_in_ready;
  assign out_data      = r_data;
  assign out_sel       = r_sel;
  assign drop_pulse    = r_drop_pulse;
  assign timeout_pulse = r_timeout_pulse;
  assign drop_cnt      = r_drop_cnt;
  assign busy          = (r_state == ISSUE);

endmodule
`default_nettype wire
